hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline control unit for the in-order RISC-V core. It watches the decode, execute and writeback stages and drives the stall, flush and bubble controls for the PC register, the fetch/decode register and the decode/execute (fetchExecute) register. It also drives the decode-stage writeback forwarding selects (forwardC/forwardD), sequences multi-cycle data-memory waits, and owns the sticky halt state. Two saturating performance counters report stall and flush activity.

## Interface
- No parameters.
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_read_reg1, id_read_reg2  in  5  source registers of the instruction in decode
- id_uses_rs1, id_uses_rs2  in  1  decode instruction actually reads rs1/rs2
- id_hlt  in  1  instruction in decode is hlt
- ex_write_reg  in  5  destination register of the instruction in execute
- ex_reg_write  in  1  execute instruction writes a register
- ex_mem_reg  in  1  execute instruction is a load
- ex_redirect  in  1  taken branch, jal or jalr resolved in execute this cycle
- wb_write_reg  in  5  writeback destination register
- wb_reg_write  in  1  writeback writes a register
- dmem_busy  in  1  data memory access not complete this cycle
- pc_write_en  out  1  PC may update
- fd_write_en  out  1  fetch/decode register may load
- fd_flush  out  1  fetch/decode register loads a NOP
- fe_write_en  out  1  decode/execute register may load
- fe_bubble  out  1  decode/execute register loads a bubble (drives in_bubble)
- forwardC, forwardD  out  1  select the writeback data for decode read data 1/2
- halted  out  1  core halted
- stall_count  out  32  cycles in which pc_write_en was 0 while not halted, saturating
- flush_count  out  32  redirects taken, saturating

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN.
- The outputs are combinational from state and inputs. The state and counters register on the rising edge.
- Control outputs are decided in this priority order: reset > HALT > dmem_busy > ex_redirect > load-use > hlt decode > normal.
- **Reset** (rst_n low): pc_write_en=0, fd_write_en=0, fe_write_en=0, fd_flush=1, fe_bubble=1, forwardC/D=0, halted=0, counters 0.
- **HALT**: pc_write_en=0, fd_write_en=0, fe_bubble=1, halted=1.
  - fe_write_en = !dmem_busy, so older instructions keep draining.
  - Only reset leaves HALT.
- **dmem_busy=1** (state RUN or MEM_WAIT): all of pc_write_en, fd_write_en and fe_write_en are 0. No bubble and no flush.
  - The next state is MEM_WAIT. The FSM returns to RUN on the first cycle dmem_busy=0.
  - A redirect or load-use condition present during the wait is acted on in that first cycle. The upstream stages are frozen, so their inputs remain valid.
- **Redirect** (ex_redirect=1): pc_write_en=1, fd_flush=1, fe_bubble=1, fe_write_en=1. flush_count increments.
  - The instruction in decode, including a hlt or a load-use victim, is discarded.
- **Load-use**: the condition is ex_mem_reg & ex_reg_write & ex_write_reg≠0 & ((id_uses_rs1 & id_read_reg1==ex_write_reg) | (id_uses_rs2 & id_read_reg2==ex_write_reg)).
  - Response: pc_write_en=0, fd_write_en=0, fe_bubble=1, fe_write_en=1.
  - The stall lasts exactly one cycle, because the bubble clears the condition.
- **hlt in decode** with no higher-priority event: fe_bubble=1, pc_write_en=0, fd_write_en=0. The next state is HALT.
- **Normal**: all write enables are 1; fd_flush=0, fe_bubble=0.
- **Forwarding** (all states except reset):
  - forwardC = wb_reg_write & wb_write_reg≠0 & wb_write_reg==id_read_reg1.
  - forwardD is the same using id_read_reg2.
  - Register x0 never forwards and never causes a stall.
- **Counters**:
  - stall_count increments on every cycle with pc_write_en=0 and state≠HALT, including the hlt-decode cycle.
  - Both counters hold at 0xFFFFFFFF.

## Timing
- The control outputs respond in the same cycle as the inputs, with zero latency. FSM and counter effects are visible after the next rising edge.
- Reset assertion forces the reset output values immediately, asynchronously. Release takes effect at the first edge with rst_n high.
- Reset mid-MEM_WAIT or mid-HALT returns the block to RUN and clears the counters.
- A dmem_busy pulse of N cycles gives exactly N frozen cycles and adds N to stall_count.
- Redirect and load-use in the same cycle: the redirect wins. stall_count is unchanged and flush_count increments by 1.

## Test plan
- Load-use: load writes x5 in EX, and decode reads x5 via rs2 → one cycle of pc_write_en=0, fe_bubble=1; next cycle normal; stall_count=1. The same case with x0 → no stall.
- Forwarding: wb writes x7 and decode reads x7 as rs1 → forwardC=1, forwardD=0. Case with wb_reg_write=0 → both 0.
- Redirect with a simultaneous load-use and an id_hlt → fd_flush=1, fe_bubble=1, pc_write_en=1; no HALT entered; flush_count=1.
- dmem_busy for 3 cycles, with ex_redirect held throughout → 3 cycles of all enables 0; in cycle 4 the redirect is taken; stall_count=3.
- hlt in decode → HALT with halted=1; the PC stays frozen for 100 cycles and stall_count does not grow beyond 1. Asserting rst_n=0 mid-halt → immediate reset outputs, then RUN.
- Saturation: preload the counters by forcing them to 0xFFFFFFFE, then give 3 stall cycles → stall_count=0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline control unit for the in-order RISC-V core.
//
// Watches decode, execute and writeback and produces the stall, flush and
// bubble controls for the PC, fetch/decode and decode/execute registers,
// the decode-stage writeback forwarding selects, the data-memory wait
// sequencing and the sticky halt state. Two saturating counters report
// stall cycles and taken redirects.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   id_read_reg1/2, id_uses_rs1/2 decode source registers and their use flags
//   id_hlt                        decode holds a hlt
//   ex_write_reg, ex_reg_write    execute destination and write flag
//   ex_mem_reg                    execute instruction is a load
//   ex_redirect                   taken branch / jal / jalr resolved in execute
//   wb_write_reg, wb_reg_write    writeback destination and write flag
//   dmem_busy                     data memory access not complete this cycle
//   pc_write_en, fd_write_en      PC / fetch-decode register load enables
//   fd_flush                      fetch-decode register loads a NOP
//   fe_write_en, fe_bubble        decode-execute register enable / bubble insert
//   forwardC, forwardD            select writeback data for decode rs1 / rs2
//   halted                        core is halted
//   stall_count, flush_count      saturating performance counters

module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_read_reg1,
    input  logic [4:0]  id_read_reg2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_hlt,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_reg_write,
    input  logic        ex_mem_reg,
    input  logic        ex_redirect,
    input  logic [4:0]  wb_write_reg,
    input  logic        wb_reg_write,
    input  logic        dmem_busy,
    output logic        pc_write_en,
    output logic        fd_write_en,
    output logic        fd_flush,
    output logic        fe_write_en,
    output logic        fe_bubble,
    output logic        forwardC,
    output logic        forwardD,
    output logic        halted,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic load_use;
    logic fwd_c_raw, fwd_d_raw;
    logic stall_inc, flush_inc;

    // x0 is hardwired to zero, so it can neither create a dependency nor
    // supply forwarded data.
    assign load_use = ex_mem_reg & ex_reg_write & (ex_write_reg != 5'd0) &
                      ((id_uses_rs1 & (id_read_reg1 == ex_write_reg)) |
                       (id_uses_rs2 & (id_read_reg2 == ex_write_reg)));

    assign fwd_c_raw = wb_reg_write & (wb_write_reg != 5'd0) &
                       (wb_write_reg == id_read_reg1);
    assign fwd_d_raw = wb_reg_write & (wb_write_reg != 5'd0) &
                       (wb_write_reg == id_read_reg2);

    // Control decode. Outputs are purely combinational so every hazard is
    // resolved in the cycle it appears. MEM_WAIT only differs from RUN in
    // that it exists to remember a wait is in progress; once dmem_busy
    // drops, the pending redirect / load-use / hlt is handled exactly as in
    // RUN because the frozen upstream stages still present the same inputs.
    always_comb begin
        pc_write_en = 1'b1;
        fd_write_en = 1'b1;
        fd_flush    = 1'b0;
        fe_write_en = 1'b1;
        fe_bubble   = 1'b0;
        forwardC    = fwd_c_raw;
        forwardD    = fwd_d_raw;
        halted      = 1'b0;
        flush_inc   = 1'b0;
        state_d     = state_q;

        if (!rst_n) begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            fd_flush    = 1'b1;
            fe_write_en = 1'b0;
            fe_bubble   = 1'b1;
            forwardC    = 1'b0;
            forwardD    = 1'b0;
            state_d     = RUN;
        end else if (state_q == HALT) begin
            // Front end frozen; older instructions keep draining whenever
            // memory lets them.
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            fe_bubble   = 1'b1;
            fe_write_en = !dmem_busy;
            halted      = 1'b1;
            state_d     = HALT;
        end else if (dmem_busy) begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            fe_write_en = 1'b0;
            state_d     = MEM_WAIT;
        end else if (ex_redirect) begin
            // Whatever sits in decode is on the wrong path, hlt included.
            fd_flush    = 1'b1;
            fe_bubble   = 1'b1;
            flush_inc   = 1'b1;
            state_d     = RUN;
        end else if (load_use) begin
            // One bubble is enough: next cycle the load has left execute.
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            fe_bubble   = 1'b1;
            state_d     = RUN;
        end else if (id_hlt) begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            fe_bubble   = 1'b1;
            state_d     = HALT;
        end else begin
            state_d     = RUN;
        end
    end

    // Halted cycles are not counted as stalls; the hlt-decode cycle is.
    assign stall_inc = !pc_write_en && (state_q != HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall_inc && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
            if (flush_inc && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of single-cycle vectors with
// hand-computed control outputs and counter updates, followed by scripted
// sequences for memory waits, halt, reset-in-halt and counter saturation.

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_read_reg1, id_read_reg2, ex_write_reg, wb_write_reg;
    logic        id_uses_rs1, id_uses_rs2, id_hlt;
    logic        ex_reg_write, ex_mem_reg, ex_redirect;
    logic        wb_reg_write, dmem_busy;
    logic        pc_write_en, fd_write_en, fd_flush, fe_write_en, fe_bubble;
    logic        forwardC, forwardD, halted;
    logic [31:0] stall_count, flush_count;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_hlt(id_hlt),
        .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_reg(ex_mem_reg), .ex_redirect(ex_redirect),
        .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
        .dmem_busy(dmem_busy),
        .pc_write_en(pc_write_en), .fd_write_en(fd_write_en),
        .fd_flush(fd_flush), .fe_write_en(fe_write_en),
        .fe_bubble(fe_bubble), .forwardC(forwardC), .forwardD(forwardD),
        .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Output bundle order: {pc_we, fd_we, fd_flush, fe_we, fe_bubble, fwdC, fwdD, halted}
    localparam logic [7:0] O_RESET  = 8'b0010_1000;
    localparam logic [7:0] O_NORM   = 8'b1101_0000;
    localparam logic [7:0] O_LDUSE  = 8'b0001_1000;
    localparam logic [7:0] O_REDIR  = 8'b1111_1000;
    localparam logic [7:0] O_BUSY   = 8'b0000_0000;
    localparam logic [7:0] O_HALT   = 8'b0001_1001;
    localparam logic [7:0] O_HALTBZ = 8'b0000_1001;

    typedef struct packed {
        logic [4:0] r1, r2;
        logic       u1, u2, hlt;
        logic [4:0] exw;
        logic       exrw, exmem, redir;
        logic [4:0] wbw;
        logic       wbrw, busy;
        logic [7:0] exp;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;
    vec_t vecs[18];
    logic [31:0] exp_stall, exp_flush;

    function automatic vec_t mk(input logic [4:0] r1, r2, input logic u1, u2, hlt,
                                input logic [4:0] exw, input logic exrw, exmem, redir,
                                input logic [4:0] wbw, input logic wbrw, busy,
                                input logic [7:0] exp);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2; v.hlt = hlt;
        v.exw = exw; v.exrw = exrw; v.exmem = exmem; v.redir = redir;
        v.wbw = wbw; v.wbrw = wbrw; v.busy = busy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {pc_write_en, fd_write_en, fd_flush, fe_write_en, fe_bubble,
                forwardC, forwardD, halted};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        id_read_reg1 = v.r1; id_read_reg2 = v.r2;
        id_uses_rs1 = v.u1;  id_uses_rs2 = v.u2; id_hlt = v.hlt;
        ex_write_reg = v.exw; ex_reg_write = v.exrw; ex_mem_reg = v.exmem;
        ex_redirect = v.redir; wb_write_reg = v.wbw; wb_reg_write = v.wbrw;
        dmem_busy = v.busy;
    endtask

    task automatic idle();
        drive(mk(5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0, 0, 5'd4, 0, 0, O_NORM));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //            r1  r2  u1 u2 hlt exw rw mem rd wbw wrw bz  expected
        vecs[0]  = mk(1,  2,  1, 1, 0,  3,  1, 0,  0, 4,  0,  0, O_NORM);
        vecs[1]  = mk(1,  5,  1, 1, 0,  5,  1, 1,  0, 4,  0,  0, O_LDUSE);   // load-use via rs2
        vecs[2]  = mk(1,  5,  1, 1, 0,  5,  1, 0,  0, 4,  0,  0, O_NORM);    // following cycle
        vecs[3]  = mk(0,  0,  1, 1, 0,  0,  1, 1,  0, 4,  0,  0, O_NORM);    // x0 never stalls
        vecs[4]  = mk(9,  2,  1, 1, 0,  9,  1, 1,  0, 4,  0,  0, O_LDUSE);   // load-use via rs1
        vecs[5]  = mk(9,  2,  0, 1, 0,  9,  1, 1,  0, 4,  0,  0, O_NORM);    // rs1 unused
        vecs[6]  = mk(9,  2,  1, 1, 0,  9,  0, 1,  0, 4,  0,  0, O_NORM);    // no reg write
        vecs[7]  = mk(7,  8,  1, 1, 0,  3,  1, 0,  0, 7,  1,  0, O_NORM | 8'b0000_0100);
        vecs[8]  = mk(7,  8,  1, 1, 0,  3,  1, 0,  0, 7,  0,  0, O_NORM);    // wb_reg_write=0
        vecs[9]  = mk(7,  8,  1, 1, 0,  3,  1, 0,  0, 8,  1,  0, O_NORM | 8'b0000_0010);
        vecs[10] = mk(8,  8,  1, 1, 0,  3,  1, 0,  0, 8,  1,  0, O_NORM | 8'b0000_0110);
        vecs[11] = mk(0,  0,  1, 1, 0,  3,  1, 0,  0, 0,  1,  0, O_NORM);    // x0 never forwards
        vecs[12] = mk(1,  5,  1, 1, 1,  5,  1, 1,  1, 4,  0,  0, O_REDIR);   // redirect beats load-use+hlt
        vecs[13] = mk(1,  2,  1, 1, 0,  3,  1, 0,  0, 4,  0,  1, O_BUSY);
        vecs[14] = mk(1,  5,  1, 1, 0,  5,  1, 1,  1, 4,  0,  1, O_BUSY);    // busy beats redirect
        vecs[15] = mk(1,  5,  1, 1, 0,  5,  1, 1,  1, 4,  0,  0, O_REDIR);   // taken after wait
        vecs[16] = mk(7,  2,  1, 1, 0,  3,  1, 0,  0, 7,  1,  1, O_BUSY | 8'b0000_0100);
        vecs[17] = mk(1,  2,  1, 1, 0,  3,  1, 0,  0, 4,  0,  0, O_NORM);

        rst_n = 1'b0;
        idle();
        #2;
        chk("reset_outs", {24'd0, outs()}, {24'd0, O_RESET});
        chk("reset_stall", stall_count, 32'd0);
        chk("reset_flush", flush_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_outs", i), {24'd0, outs()}, {24'd0, vecs[i].exp});
            if (!vecs[i].exp[7]) exp_stall++;
            if (vecs[i].exp[5]) exp_flush++;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_stall", i), stall_count, exp_stall);
            chk($sformatf("vec%0d_flush", i), flush_count, exp_flush);
        end

        // Three-cycle memory wait with a redirect pending throughout.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(mk(1, 2, 1, 1, 0, 3, 1, 0, 1, 4, 0, (c < 3), O_NORM));
            #1;
            chk($sformatf("wait_c%0d", c), {24'd0, outs()},
                {24'd0, (c < 3) ? O_BUSY : O_REDIR});
        end
        @(posedge clk);
        #1;
        chk("wait_stall", stall_count, 32'd3);
        chk("wait_flush", flush_count, 32'd1);

        // hlt in decode, then a long halt with the PC frozen.
        do_reset();
        @(negedge clk);
        drive(mk(1, 2, 1, 1, 1, 3, 1, 0, 0, 4, 0, 0, O_NORM));
        #1;
        chk("hlt_decode", {24'd0, outs()}, {24'd0, O_LDUSE});
        @(posedge clk);
        #1;
        chk("hlt_halted", {24'd0, outs()}, {24'd0, O_HALT});
        chk("hlt_stall", stall_count, 32'd1);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            // Redirects and memory waits are ignored while halted, except that
            // draining stops while memory is busy.
            drive(mk(1, 2, 1, 1, 0, 3, 1, 0, (c % 7 == 0), 4, 0, (c % 5 == 0), O_NORM));
            #1;
            chk($sformatf("halt_c%0d", c), {24'd0, outs()},
                {24'd0, (c % 5 == 0) ? O_HALTBZ : O_HALT});
        end
        @(posedge clk);
        #1;
        chk("halt_stall", stall_count, 32'd1);
        chk("halt_flush", flush_count, 32'd0);
        #2;
        rst_n = 1'b0;
        idle();
        #1;
        chk("halt_rst_outs", {24'd0, outs()}, {24'd0, O_RESET});
        chk("halt_rst_stall", stall_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("halt_rst_run", {24'd0, outs()}, {24'd0, O_NORM});

        // Saturation of the stall counter.
        @(negedge clk);
        idle();
        force dut.stall_count = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(mk(1, 2, 1, 1, 0, 3, 1, 0, 0, 4, 0, 1, O_NORM));
        end
        @(posedge clk);
        #1;
        chk("sat_stall", stall_count, 32'hFFFF_FFFF);
        @(negedge clk);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
